// File: rtl/soc_imem_loader_if.sv
// Byte stream in, IMEM write port and status out.
// master: the loader (consumes the byte stream, drives IMEM and status).
// slave : the surrounding SoC (produces bytes, observes IMEM writes).
interface soc_imem_loader_if;
    logic        rx_vld;
    logic [7:0]  rx_dat;
    logic        imem_cpu_rstn;
    logic        imem_we;
    logic [29:0] imem_waddr;
    logic [31:0] imem_wdat;
    logic        busy;
    logic        err;

    modport master (
        input  rx_vld, rx_dat,
        output imem_cpu_rstn, imem_we, imem_waddr, imem_wdat, busy, err
    );

    modport slave (
        output rx_vld, rx_dat,
        input  imem_cpu_rstn, imem_we, imem_waddr, imem_wdat, busy, err
    );
endinterface

// File: rtl/soc_imem_loader.sv
// soc_imem_loader: reloads the CPU program memory from a framed byte stream.
// Frame: MAGIC (4 bytes, MSB first), N (16-bit LE), 4*N data bytes (LE words),
// then an 8-bit modulo-256 sum of the data bytes. The CPU is held in reset
// from the magic match until a frame ends with a good checksum.
// Optional macro LOADER_TIMEOUT_EN: abort a frame when the gap between bytes
// reaches TIMEOUT_CYC clocks.
module soc_imem_loader #(
    parameter int          NUM_WORDS_IMEM = 8192,
    parameter logic [29:0] BASE_WADDR     = 30'h0,
    parameter logic [31:0] MAGIC          = 32'h5747_4C44,
    parameter int          TIMEOUT_CYC    = 1_000_000
) (
    input logic               clk,
    input logic               arst_n,
    soc_imem_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] shreg_reg, shreg_next;
    logic [15:0] n_reg, n_next;
    logic [15:0] idx_reg, idx_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [23:0] word_reg, word_next;
    logic [7:0]  csum_reg, csum_next;
    logic        cpu_rstn_reg, cpu_rstn_next;
    logic        we_reg, we_next;
    logic [29:0] waddr_reg, waddr_next;
    logic [31:0] wdat_reg, wdat_next;
    logic        busy_reg, busy_next;
    logic        err_reg, err_next;

    logic [2:0]  lane_we;
    logic [15:0] n_full;
    logic [15:0] idx_inc;

    assign n_full  = {bus.rx_dat, n_reg[7:0]};
    assign idx_inc = idx_reg + 16'd1;

    // The first three bytes of each word are parked in their byte lanes; the
    // fourth byte goes straight into the write data, so the next word can
    // start assembling on the very next clock.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_we[gi] = (state_reg == DATA) && bus.rx_vld &&
                                 (byte_idx_reg == 2'(gi));
            assign word_next[8*gi +: 8] = lane_we[gi] ? bus.rx_dat
                                                      : word_reg[8*gi +: 8];
        end
    endgenerate

`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] tmo_cnt_reg, tmo_cnt_next;
`endif

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        n_next        = n_reg;
        idx_next      = idx_reg;
        byte_idx_next = byte_idx_reg;
        csum_next     = csum_reg;
        cpu_rstn_next = cpu_rstn_reg;
        we_next       = 1'b0;
        waddr_next    = waddr_reg;
        wdat_next     = wdat_reg;
        busy_next     = busy_reg;
        err_next      = err_reg;
`ifdef LOADER_TIMEOUT_EN
        tmo_cnt_next  = 32'd0;
`endif

        unique case (state_reg)
            IDLE, ERR: begin
                if (bus.rx_vld) begin
                    shreg_next = {shreg_reg[23:0], bus.rx_dat};
                    if ({shreg_reg[23:0], bus.rx_dat} == MAGIC) begin
                        state_next    = LEN;
                        cpu_rstn_next = 1'b0;
                        busy_next     = 1'b1;
                        err_next      = 1'b0;
                        byte_idx_next = 2'd0;
                    end
                end
            end

            LEN: begin
                if (bus.rx_vld) begin
                    if (!byte_idx_reg[0]) begin
                        n_next[7:0]   = bus.rx_dat;
                        byte_idx_next = 2'd1;
                    end else begin
                        n_next        = n_full;
                        byte_idx_next = 2'd0;
                        if (n_full == 16'd0 ||
                            32'(n_full) > 32'(NUM_WORDS_IMEM)) begin
                            state_next = ERR;
                            err_next   = 1'b1;
                            busy_next  = 1'b0;
                            shreg_next = 32'd0;
                        end else begin
                            state_next = DATA;
                            idx_next   = 16'd0;
                            csum_next  = 8'd0;
                        end
                    end
                end
            end

            DATA: begin
                if (bus.rx_vld) begin
                    csum_next     = csum_reg + bus.rx_dat;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        we_next    = 1'b1;
                        waddr_next = BASE_WADDR + 30'(idx_reg);
                        wdat_next  = {bus.rx_dat, word_reg};
                        idx_next   = idx_inc;
                        if (idx_inc == n_reg) begin
                            state_next = CSUM;
                        end
                    end
                end
            end

            CSUM: begin
                if (bus.rx_vld) begin
                    busy_next  = 1'b0;
                    shreg_next = 32'd0;
                    if (bus.rx_dat == csum_reg) begin
                        state_next    = IDLE;
                        cpu_rstn_next = 1'b1;
                    end else begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                shreg_next = 32'd0;
            end
        endcase

`ifdef LOADER_TIMEOUT_EN
        // Inter-byte gap watchdog while a frame is open.
        if (state_reg == LEN || state_reg == DATA || state_reg == CSUM) begin
            if (!bus.rx_vld) begin
                if (tmo_cnt_reg == TMO_LAST) begin
                    state_next = ERR;
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    shreg_next = 32'd0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 32'd1;
                end
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers; reset puts the power-up image back in control.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shreg_reg    <= 32'd0;
            n_reg        <= 16'd0;
            idx_reg      <= 16'd0;
            byte_idx_reg <= 2'd0;
            word_reg     <= 24'd0;
            csum_reg     <= 8'd0;
            cpu_rstn_reg <= 1'b1;
            we_reg       <= 1'b0;
            waddr_reg    <= BASE_WADDR;
            wdat_reg     <= 32'd0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            shreg_reg    <= shreg_next;
            n_reg        <= n_next;
            idx_reg      <= idx_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            csum_reg     <= csum_next;
            cpu_rstn_reg <= cpu_rstn_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdat_reg     <= wdat_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Idle-gap counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tmo_cnt_reg <= 32'd0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
`endif

    assign bus.imem_cpu_rstn = cpu_rstn_reg;
    assign bus.imem_we       = we_reg;
    assign bus.imem_waddr    = waddr_reg;
    assign bus.imem_wdat     = wdat_reg;
    assign bus.busy          = busy_reg;
    assign bus.err           = err_reg;

endmodule
